vga_scan_gen: RTL and testbench
===============================

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_VIS 800: visible pixels per line
- H_FP 40: horizontal front porch
- H_SYNC 128: hsync width
- H_BP 88: horizontal back porch
- V_VIS 600: visible lines
- V_FP 1: vertical front porch
- V_SYNC 4: vsync width
- V_BP 23: vertical back porch
- DELT_MAX 200: maximum logo offset
- DELT_STEP 2: offset change per frame
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- pix_en  in  1  pixel-rate clock enable; counters advance only when high
- anim_en  in  1  logo offset animation enable
- x  out  11  current horizontal count, consumed as painter x
- y  out  11  current vertical count, consumed as painter y
- hsync  out  1  horizontal sync, active-high
- vsync  out  1  vertical sync, active-high
- video_on  out  1  current (x,y) lies in the visible area
- frame_start  out  1  one-cycle pulse at the start of each new frame
- delt  out  11  horizontal logo offset, consumed as painter delt
REQ-003 The design SHALL use exactly one clock domain (clk), with no derived or gated clocks.

Function
REQ-004 H_TOT = H_VIS+H_FP+H_SYNC+H_BP (1056 by default) and V_TOT = V_VIS+V_FP+V_SYNC+V_BP (628 by default).
REQ-005 x SHALL be an 11-bit register that increments by 1 on each clk edge with pix_en=1, and wraps from H_TOT-1 to 0.
REQ-006 y SHALL increment by 1 only on the edge where x wraps, and SHALL wrap from V_TOT-1 to 0 on the edge where x and y both wrap.
REQ-007 With pix_en=0, x, y, delt and the animation state SHALL hold.
REQ-008 The following outputs SHALL be combinational decodes of the current x and y, forced to 0 while rst=1:
- hsync = 1 iff H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC (840..967 by default)
- vsync = 1 iff V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC (601..604 by default)
- video_on = 1 iff x < H_VIS and y < V_VIS
REQ-009 frame_start SHALL be registered and SHALL be 1 for exactly one clk cycle: the cycle in which (x,y) has just wrapped to (0,0) from (H_TOT-1,V_TOT-1).
REQ-010 frame_start SHALL NOT assert on reset release.
REQ-011 The animation FSM SHALL have two states, RIGHT and LEFT, and SHALL update only on the clock edge where the frame wraps, so the new delt is valid together with frame_start.
REQ-012 In RIGHT with anim_en=1:
- if delt+DELT_STEP >= DELT_MAX: delt <= DELT_MAX and the state goes to LEFT
- otherwise: delt <= delt+DELT_STEP
REQ-013 In LEFT with anim_en=1:
- if delt <= DELT_STEP: delt <= 0 and the state goes to RIGHT
- otherwise: delt <= delt-DELT_STEP
REQ-014 With anim_en=0 at the frame wrap, delt and the state SHALL hold; no other condition changes delt.
REQ-015 delt SHALL never leave 0..DELT_MAX and SHALL never wrap modulo 2^11.
REQ-016 Arithmetic SHALL be 11-bit unsigned. Parameters SHALL satisfy H_TOT, V_TOT <= 2047 and DELT_MAX+DELT_STEP <= 2047.

Reset
REQ-017 On a clk edge with rst=1, the block SHALL load: x=0, y=0, delt=0, state=RIGHT, frame_start=0.
REQ-018 rst SHALL override pix_en and anim_en.
REQ-019 Reset asserted mid-line or mid-frame SHALL abort the scan; the next scan starts at (0,0) with no frame_start pulse.

Verification
REQ-020 Free run: pix_en=1 held for 2 frames -> x sequence 1055->0, y sequence 627->0, and exactly one frame_start per 663168 cycles.
REQ-021 Sync windows:
- at y=0: hsync=1 for x=840..967 only
- vsync=1 for y=601..604 only
- video_on=0 at x=800 and at y=600
REQ-022 Enable gating: pix_en toggling 1,0,1,0 -> x advances once per two clk cycles. A frame_start that coincides with a stall still lasts one cycle.
REQ-023 Animation bounce: anim_en=1 over 102 frames -> delt goes 0,2,...,200 (reaching 200 at frame 100), then 198 at frame 101 and 196 at frame 102. delt reaches 0 again at frame 200 with state RIGHT.
REQ-024 Freeze: anim_en=0 for 5 frames at delt=50 -> delt stays 50. On re-enable, delt continues in the same direction.
REQ-025 Mid-frame reset: rst pulsed for 1 cycle at (x=500,y=300,delt=80) -> next cycle x=0, y=0, delt=0, hsync=vsync=0, frame_start=0.

Source files
------------

// File: rtl/vga_scan_gen_if.sv
// Scan-generator bundle: pixel/animation enables in, raster position,
// sync decodes, frame pulse and logo offset out.
//   master : the scan generator (drives timing outputs)
//   slave  : the consumer/painter (drives the enables)
interface vga_scan_gen_if;
   logic        pix_en;
   logic        anim_en;
   logic [10:0] x;
   logic [10:0] y;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic        frame_start;
   logic [10:0] delt;

   modport master (
      input  pix_en, anim_en,
      output x, y, hsync, vsync, video_on, frame_start, delt
   );

   modport slave (
      output pix_en, anim_en,
      input  x, y, hsync, vsync, video_on, frame_start, delt
   );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator with a bouncing horizontal logo offset.
//
// Ports:
//   clk  : single clock, all state changes on its rising edge
//   rst  : synchronous, active-high reset
//   bus  : vga_scan_gen_if.master
//          pix_en      pixel-rate enable; counters/animation advance only when high
//          anim_en     logo offset animation enable
//          x, y        current horizontal/vertical count (11 bit)
//          hsync/vsync active-high sync decodes of x/y
//          video_on    (x,y) inside the visible area
//          frame_start one-cycle pulse after the raster wraps to (0,0)
//          delt        horizontal logo offset, 0..DELT_MAX
//
// Animation FSM
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_RIGHT | offset grows by DELT_STEP per frame, clamps at DELT_MAX
//   ST_LEFT  | offset shrinks by DELT_STEP per frame, clamps at 0
module vga_scan_gen #(
   parameter int H_VIS     = 800,
   parameter int H_FP      = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BP      = 88,
   parameter int V_VIS     = 600,
   parameter int V_FP      = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BP      = 23,
   parameter int DELT_MAX  = 200,
   parameter int DELT_STEP = 2
) (
   input  logic           clk,
   input  logic           rst,
   vga_scan_gen_if.master bus
);

   localparam logic [10:0] H_LAST   = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_LAST   = 11'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] HS_BEG   = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG   = 11'(V_VIS + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);
   localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
   localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
   localparam logic [10:0] D_MAX    = 11'(DELT_MAX);
   localparam logic [10:0] D_STEP   = 11'(DELT_STEP);

   typedef enum logic {
      ST_RIGHT = 1'b0,
      ST_LEFT  = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_nxt;
   logic [10:0] x_q;
   logic [10:0] y_q;
   logic [10:0] delt_q;
   logic [10:0] delt_nxt;
   logic        frame_start_q;
   logic        x_wrap;
   logic        y_wrap;
   logic        frame_wrap;

   assign x_wrap     = (x_q == H_LAST);
   assign y_wrap     = (y_q == V_LAST);
   assign frame_wrap = bus.pix_en & x_wrap & y_wrap;

   // raster counters
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else if (bus.pix_en) begin
         if (x_wrap) begin
            x_q <= '0;
            y_q <= y_wrap ? 11'd0 : y_q + 11'd1;
         end else begin
            x_q <= x_q + 11'd1;
         end
      end
   end

   // Pulse follows the wrap edge itself, so it clears on the next clk edge
   // even if pix_en is low then.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= frame_wrap;
      end
   end

   // animation FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RIGHT;
         delt_q  <= '0;
      end else begin
         state_q <= state_nxt;
         delt_q  <= delt_nxt;
      end
   end

   // animation FSM: next state. Moves only on the frame-wrap edge so the new
   // offset appears together with frame_start. delt never exceeds D_MAX, and
   // D_MAX+D_STEP fits in 11 bits, so the sum below cannot overflow.
   always_comb begin
      state_nxt = state_q;
      delt_nxt  = delt_q;
      if (frame_wrap && bus.anim_en) begin
         case (state_q)
            ST_RIGHT: begin
               if (delt_q + D_STEP >= D_MAX) begin
                  delt_nxt  = D_MAX;
                  state_nxt = ST_LEFT;
               end else begin
                  delt_nxt  = delt_q + D_STEP;
               end
            end
            ST_LEFT: begin
               if (delt_q <= D_STEP) begin
                  delt_nxt  = '0;
                  state_nxt = ST_RIGHT;
               end else begin
                  delt_nxt  = delt_q - D_STEP;
               end
            end
            default: begin
               delt_nxt  = '0;
               state_nxt = ST_RIGHT;
            end
         endcase
      end
   end

   // outputs: raster decodes, blanked while reset is asserted
   always_comb begin
      bus.x           = x_q;
      bus.y           = y_q;
      bus.delt        = delt_q;
      bus.frame_start = frame_start_q;
      bus.hsync       = 1'b0;
      bus.vsync       = 1'b0;
      bus.video_on    = 1'b0;
      if (!rst) begin
         bus.hsync    = (x_q >= HS_BEG) && (x_q < HS_END);
         bus.vsync    = (y_q >= VS_BEG) && (y_q < VS_END);
         bus.video_on = (x_q < H_VIS_W) && (y_q < V_VIS_W);
      end
   end

endmodule

// File: tb/tb_vga_scan_gen.sv
module tb_vga_scan_gen;

   // reduced raster so many frames fit in a short run
   localparam int H_VIS = 8,  H_FP = 2, H_SYNC = 3, H_BP = 2;
   localparam int V_VIS = 4,  V_FP = 1, V_SYNC = 2, V_BP = 1;
   localparam int D_MAX = 20, D_STEP = 3;
   localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;   // 15
   localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;   // 8

   logic clk = 1'b0;
   logic rst = 1'b1;
   vga_scan_gen_if bus ();

   vga_scan_gen #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .DELT_MAX(D_MAX), .DELT_STEP(D_STEP)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: raster position, offset, direction (0 right, 1 left)
   int   mx = 0, my = 0, md = 0, mdir = 0;
   logic mfs = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_decode(input logic r);
      logic ehs, evs, evo;
      ehs = !r && mx >= H_VIS + H_FP && mx < H_VIS + H_FP + H_SYNC;
      evs = !r && my >= V_VIS + V_FP && my < V_VIS + V_FP + V_SYNC;
      evo = !r && mx < H_VIS && my < V_VIS;
      chk("hsync", 32'(bus.hsync), 32'(ehs));
      chk("vsync", 32'(bus.vsync), 32'(evs));
      chk("video_on", 32'(bus.video_on), 32'(evo));
   endtask

   task automatic chk_all(input logic r);
      chk("x", 32'(bus.x), 32'(mx));
      chk("y", 32'(bus.y), 32'(my));
      chk("delt", 32'(bus.delt), 32'(md));
      chk("frame_start", 32'(bus.frame_start), 32'(mfs));
      chk_decode(r);
   endtask

   task automatic step(input logic pe, input logic ae, input logic r);
      logic wrap;
      rst         = r;
      bus.pix_en  = pe;
      bus.anim_en = ae;
      #1;
      chk_decode(r);
      @(posedge clk);
      if (r) begin
         mx = 0; my = 0; md = 0; mdir = 0; mfs = 1'b0;
      end else begin
         wrap = pe && mx == HT - 1 && my == VT - 1;
         mfs  = wrap;
         if (wrap && ae) begin
            if (mdir == 0) begin
               if (md + D_STEP >= D_MAX) begin md = D_MAX; mdir = 1; end
               else md = md + D_STEP;
            end else begin
               if (md <= D_STEP) begin md = 0; mdir = 0; end
               else md = md - D_STEP;
            end
         end
         if (pe) begin
            if (mx == HT - 1) begin
               mx = 0;
               my = (my == VT - 1) ? 0 : my + 1;
            end else begin
               mx = mx + 1;
            end
         end
      end
      @(negedge clk);
      chk_all(r);
   endtask

   task automatic run_frame(input logic ae);
      int n;
      n = 0;
      do begin
         step(1'b1, ae, 1'b0);
         n++;
      end while (!mfs && n < 2 * HT * VT);
      chk("run_frame_bound", 32'(mfs), 32'd1);
   endtask

   task automatic run_to(input int tx, input int ty, input logic ae);
      int n;
      n = 0;
      while (!(mx == tx && my == ty) && n < 2 * HT * VT) begin
         step(1'b1, ae, 1'b0);
         n++;
      end
      chk("run_to_bound", 32'(mx == tx && my == ty), 32'd1);
   endtask

   initial begin
      int fs_cnt;
      logic ae;
      bus.pix_en  = 1'b1;
      bus.anim_en = 1'b1;

      // reset overrides enables
      repeat (3) step(1'b1, 1'b1, 1'b1);
      chk("rst_x", 32'(bus.x), 32'd0);
      chk("rst_fs", 32'(bus.frame_start), 32'd0);

      // free run: one frame_start per HT*VT pixel cycles, none on release
      fs_cnt = 0;
      for (int i = 0; i < 2 * HT * VT; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (bus.frame_start === 1'b1) fs_cnt++;
      end
      chk("fs_per_2frames", 32'(fs_cnt), 32'd2);

      // sync windows on line 0 and at the corner cases
      run_to(H_VIS + H_FP, 0, 1'b0);
      chk("hsync_start", 32'(bus.hsync), 32'd1);
      run_to(H_VIS + H_FP + H_SYNC, 0, 1'b0);
      chk("hsync_end", 32'(bus.hsync), 32'd0);
      run_to(3, V_VIS, 1'b0);
      chk("video_off_row", 32'(bus.video_on), 32'd0);
      run_to(2, V_VIS + V_FP, 1'b0);
      chk("vsync_on", 32'(bus.vsync), 32'd1);

      // pix_en toggling, including a stall right after the frame wrap
      for (int i = 0; i < 40; i++) step(1'(i % 2 == 0), 1'b0, 1'b0);
      run_to(HT - 1, VT - 1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("fs_at_wrap", 32'(bus.frame_start), 32'd1);
      step(1'b0, 1'b0, 1'b0);
      chk("fs_stall_len", 32'(bus.frame_start), 32'd0);
      chk("x_stall_hold", 32'(bus.x), 32'd0);

      // bounce from a fresh reset: 3,6,...,18,20(clamp),17,14,11
      step(1'b1, 1'b1, 1'b1);
      for (int f = 1; f <= 10; f++) begin
         run_frame(1'b1);
         if (f == 6) chk("delt_f6", 32'(bus.delt), 32'd18);
         if (f == 7) chk("delt_f7_clamp", 32'(bus.delt), 32'd20);
         if (f == 8) chk("delt_f8", 32'(bus.delt), 32'd17);
      end
      chk("delt_f10", 32'(bus.delt), 32'd11);

      // freeze, then continue leftwards
      repeat (5) run_frame(1'b0);
      chk("delt_frozen", 32'(bus.delt), 32'd11);
      run_frame(1'b1);
      chk("delt_resume", 32'(bus.delt), 32'd8);
      run_frame(1'b1);
      run_frame(1'b1);
      chk("delt_2", 32'(bus.delt), 32'd2);
      run_frame(1'b1);
      chk("delt_floor", 32'(bus.delt), 32'd0);
      run_frame(1'b1);
      chk("delt_right_again", 32'(bus.delt), 32'd3);

      // mid-frame reset aborts scan and offset
      run_to(7, 3, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk("mid_rst_x", 32'(bus.x), 32'd0);
      chk("mid_rst_y", 32'(bus.y), 32'd0);
      chk("mid_rst_delt", 32'(bus.delt), 32'd0);
      chk("mid_rst_fs", 32'(bus.frame_start), 32'd0);
      repeat (3) step(1'b1, 1'b1, 1'b0);

      // randomized run against the model
      ae = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 199) == 0) ae = ~ae;
         step(1'($urandom_range(0, 3) != 0), ae, 1'($urandom_range(0, 799) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
